// File: rtl/lsu_bridge_if.sv
// Core-side load/store request/response and memory-side request/ack signals of the LSU bridge.
// The slave modport is the bridge view; the master modport is the core and memory view.
interface lsu_bridge_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_mode;
    logic        stall;
    logic [31:0] rsp_rdata;
    logic        rsp_valid;
    logic        misalign_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_mode, mem_ack, mem_rdata,
        output stall, rsp_rdata, rsp_valid, misalign_err, bus_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_mode, mem_ack, mem_rdata,
        input  stall, rsp_rdata, rsp_valid, misalign_err, bus_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/lsu_bridge.sv
// Bridges core loads/stores onto a single-outstanding word memory bus with a bounded ack wait.
// Latency: zero-wait access stalls the core 2 cycles, rsp_valid in cycle 3; the core is stalled while memory withholds mem_ack.
module lsu_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    lsu_bridge_if.slave  bus
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    mode_q;
    logic [1:0]    off_q;
    logic          we_q;
    logic          bus_err_q;

    logic          aligned;
    logic          accept;
    logic [3:0]    be_n;
    logic [31:0]   wdata_n;
    logic [31:0]   shifted;
    logic [31:0]   load_data;

    // Unsupported funct3 codes fall into the default arm and are reported as misaligned.
    always_comb begin
        aligned = 1'b0;
        case (bus.req_mode)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~bus.req_addr[0];
            3'b010:         aligned = (bus.req_addr[1:0] == 2'b00);
            default:        aligned = 1'b0;
        endcase
    end

    assign accept           = (state == IDLE) && bus.req_valid && aligned;
    assign bus.stall        = accept || (state == BUSY);
    assign bus.misalign_err = (state == IDLE) && bus.req_valid && !aligned;
    assign bus.rsp_valid    = (state == DONE);
    assign bus.bus_err      = (state == DONE) && bus_err_q;

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = bus.req_wdata;
        case (bus.req_mode[1:0])
            2'b00: begin
                be_n    = 4'b0001 << bus.req_addr[1:0];
                wdata_n = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be_n    = 4'b0011 << bus.req_addr[1:0];
                wdata_n = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = bus.req_wdata;
            end
        endcase
        if (!bus.req_we) begin
            be_n = 4'b1111;
        end
    end

    // Selected lane is brought down to bit 0 first, then extended by access size and signedness.
    always_comb begin
        shifted   = bus.mem_rdata >> {off_q, 3'b000};
        load_data = shifted;
        case (mode_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            mode_q        <= 3'b000;
            off_q         <= 2'b00;
            we_q          <= 1'b0;
            bus_err_q     <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            bus.mem_be    <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= BUSY;
                        cnt           <= '0;
                        mode_q        <= bus.req_mode;
                        off_q         <= bus.req_addr[1:0];
                        we_q          <= bus.req_we;
                        bus_err_q     <= 1'b0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.req_we;
                        bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                        bus.mem_wdata <= wdata_n;
                        bus.mem_be    <= be_n;
                    end
                end
                BUSY: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (bus.mem_ack) begin
                        state         <= DONE;
                        cnt           <= '0;
                        bus_err_q     <= 1'b0;
                        bus.rsp_rdata <= we_q ? 32'h0 : load_data;
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_be    <= 4'b0000;
                    end else if (cnt == CNT_LAST) begin
                        state         <= DONE;
                        cnt           <= '0;
                        bus_err_q     <= 1'b1;
                        bus.rsp_rdata <= 32'h0;
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_be    <= 4'b0000;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    bus_err_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_bridge.md
LSU_BRIDGE -- requirements
Module: lsu_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16, is the maximum number of cycles spent waiting for mem_ack before a bus error.
REQ-002 clk  in  1  rising-edge clock, the same clock as the processor core.
REQ-003 rst  in  1  reset; synchronous and active-low (0 resets on a clk rising edge).
REQ-004 req_valid  in  1  core presents a load or store this cycle (the core's rd_en | wr_en).
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 req_addr  in  32  byte address (the core's ALU result).
REQ-007 req_wdata  in  32  store data (the core's rs2 value).
REQ-008 req_mode  in  3  funct3 encoding: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-009 stall  out  1  freezes the core's PC and register-file write while 1.
REQ-010 rsp_rdata  out  32  aligned, extended load data; valid when rsp_valid=1.
REQ-011 rsp_valid  out  1  one-cycle pulse marking completion of a load or store.
REQ-012 misalign_err  out  1  one-cycle pulse for a misaligned request.
REQ-013 bus_err  out  1  one-cycle pulse for a timed-out request; coincides with rsp_valid.
REQ-014 mem_req  out  1  memory request; held high until it is acknowledged.
REQ-015 mem_we  out  1  memory write enable.
REQ-016 mem_addr  out  32  word address, with bits [1:0] = 00.
REQ-017 mem_wdata  out  32  store data replicated into the active byte lanes.
REQ-018 mem_be  out  4  byte enables.
REQ-019 mem_ack  in  1  memory completes the request in this cycle.
REQ-020 mem_rdata  in  32  read word; valid when mem_ack=1.

Function
REQ-021 The FSM shall have three states: IDLE, BUSY and DONE.
REQ-022 Alignment: LH, LHU and SH require addr[0]=0; LW and SW require addr[1:0]=00; byte accesses are always aligned.
REQ-023 Unsupported modes 011, 110 and 111 shall be treated as misaligned.
REQ-024 IDLE with req_valid=1 and the request aligned: register addr, mode, we and wdata; assert stall combinationally; transition to BUSY.
REQ-025 IDLE with req_valid=1 and the request misaligned: misalign_err=1 for that cycle, stall=0, no memory access, remain in IDLE.
REQ-026 BUSY: drive mem_req=1 and the registered mem_we, mem_addr, mem_be and mem_wdata, all held stable; stall=1; the timeout counter increments each cycle.
REQ-027 BUSY with mem_ack=1: capture the formatted mem_rdata into rsp_rdata; clear the counter; transition to DONE.
REQ-028 BUSY with the counter reaching TIMEOUT-1 and mem_ack=0: set rsp_rdata=0, set bus_err=1 in DONE, drop mem_req; transition to DONE.
REQ-029 If mem_ack and the timeout condition occur in the same cycle, the ack wins (no bus_err).
REQ-030 DONE: rsp_valid=1 and stall=0 for exactly one cycle; req_valid is ignored in DONE; transition to IDLE.
REQ-031 Latency: a zero-wait memory (ack in the first BUSY cycle) gives stall high for 2 cycles (IDLE, BUSY) and rsp_valid in the 3rd cycle.
REQ-032 Byte enables for stores: SB gives 0001<<addr[1:0]; SH gives 0011<<addr[1:0]; SW gives 1111.
REQ-033 Byte enables for loads: mem_be=1111.
REQ-034 Store data: mem_wdata = {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, and wdata for SW.
REQ-035 Load formatting: the byte or halfword is selected by addr[1:0].
REQ-036 Load extension: LB and LH sign-extend; LBU and LHU zero-extend.
REQ-037 For stores, rsp_rdata shall be 0.
REQ-038 mem_req shall never be asserted in IDLE or DONE.
REQ-039 mem_ack arriving outside BUSY shall be ignored.
REQ-040 The counter shall be wide enough to hold TIMEOUT-1 and shall never wrap while in BUSY.

Reset
REQ-041 rst=0 at a clk edge: state=IDLE and counter=0, regardless of current state; this includes mid-BUSY, which abandons the access.
REQ-042 Outputs after reset: stall=0, rsp_valid=0, misalign_err=0, bus_err=0, mem_req=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0, rsp_rdata=0.
REQ-043 The first request shall be accepted on the first edge at which rst=1.

Verification
REQ-044 LB, addr=0x103, mem_rdata=0x80112233, ack on the 1st BUSY cycle -> mem_addr=0x100, mem_be=1111, rsp_rdata=0xFFFFFF80, stall high for 2 cycles, rsp_valid in cycle 3.
REQ-045 SH, addr=0x202, wdata=0x0000BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF, rsp_rdata=0.
REQ-046 LW, addr=0x301 -> misalign_err pulse, stall=0, mem_req never asserted.
REQ-047 LHU, addr=0x402, mem_rdata=0xF00D1234, ack after 3 wait cycles -> mem_req held with stable address for 4 cycles, rsp_rdata=0x0000F00D.
REQ-048 No ack with TIMEOUT=16 -> mem_req high for 16 cycles, then bus_err and rsp_valid together, rsp_rdata=0.
REQ-049 rst=0 in the 2nd BUSY cycle -> the next cycle shows mem_req=0, stall=0 and IDLE; a subsequent LW completes normally.
